// File: rtl/exp2_10bit.sv
// exp2_10bit - sequential fixed-point base-2 antilog.
//
// Converts an unsigned Q11.10 log-domain value back to a 64-bit linear value,
// outdata = round(2^indata), saturating at all ones. The fractional part is
// evaluated as a product of constants 2^(2^-k), one multiply per cycle with a
// single 24x24 multiplier (mantissa Q1.23). The integer part is then applied
// as a left shift.
//
// Ports:
//   clk      in   clock, rising edge
//   rst_n    in   asynchronous active-low reset (release synchronised inside)
//   start    in   level request, sampled only while idle
//   indata   in   [20:0] Q11.10 exponent (int [20:10], frac [9:0])
//   outdata  out  [63:0] result, held between conversions
//   dv       out  one-cycle pulse when outdata is updated
//   busy     out  high whenever a conversion is in flight
//
// Timing: accept at edge N, multiplies on N+1..N+10, result and dv at N+11,
// next accept possible at N+12 (one result every 12 cycles back-to-back).

module exp2_10bit #(
  parameter int FRAC_BITS = 10,
  parameter int MANT_W    = 24
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic [FRAC_BITS+10:0]      indata,
  output logic [63:0]                outdata,
  output logic                       dv,
  output logic                       busy
);

  localparam int INT_W  = 11;
  localparam int PROD_W = 2 * MANT_W;
  // Shift datapath: mantissa shifted by up to 63, plus a spare carry bit.
  localparam int SH_W   = MANT_W + 64;
  localparam int RES_W  = SH_W - (MANT_W - 1);

  localparam logic [MANT_W-1:0] ONE    = MANT_W'(1) << (MANT_W - 1);
  localparam logic [PROD_W-1:0] RND_P  = PROD_W'(1) << (MANT_W - 2);
  localparam logic [SH_W-1:0]   RND_S  = SH_W'(1) << (MANT_W - 2);
  localparam logic [3:0]        K_LAST = 4'(FRAC_BITS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_SHIFT
  } state_e;

  state_e                 state_q;
  logic [1:0]             rst_sync_q;
  logic [INT_W-1:0]       int_q;
  logic [FRAC_BITS-1:0]   frac_q;
  logic [MANT_W-1:0]      m_q;
  logic [MANT_W-1:0]      m_d;
  logic [3:0]             k_q;
  logic [MANT_W-1:0]      c_k;
  logic [PROD_W-1:0]      prod_rnd;
  logic [SH_W-1:0]        sh_sum;
  logic [RES_W-1:0]       sh_res;
  logic [63:0]            out_d;
  logic [63:0]            outdata_q;
  logic                   dv_q;
  logic                   busy_q;

  // Reset asserts asynchronously everywhere; its release reaches the FSM
  // through two flops, so start is only honoured once run_ok is set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync_q <= '0;
    else        rst_sync_q <= {rst_sync_q[0], 1'b1};
  end

  // C_k = round(2^(2^-k) * 2^23), Q1.23.
  always_comb begin
    c_k = ONE;
    case (k_q)
      4'd1:  c_k = 24'd11863283;
      4'd2:  c_k = 24'd9975792;
      4'd3:  c_k = 24'd9147842;
      4'd4:  c_k = 24'd8760003;
      4'd5:  c_k = 24'd8572295;
      4'd6:  c_k = 24'd8479954;
      4'd7:  c_k = 24'd8434157;
      4'd8:  c_k = 24'd8411352;
      4'd9:  c_k = 24'd8399972;
      4'd10: c_k = 24'd8394288;
      default: c_k = ONE;
    endcase
  end

  // M * C_k rounded half-up back to Q1.23. Both factors are in [1,2), the
  // running product stays below 2 because the total fraction is below 1.
  always_comb begin
    prod_rnd = (PROD_W'(m_q) * PROD_W'(c_k)) + RND_P;
    m_d      = MANT_W'(prod_rnd >> (MANT_W - 1));
  end

  // Integer scaling: (M << int) rounded back to an integer. The low 6 bits
  // of int_q cover the in-range shifts; anything at 64 or above saturates.
  always_comb begin
    sh_sum = (SH_W'(m_q) << int_q[5:0]) + RND_S;
    sh_res = RES_W'(sh_sum >> (MANT_W - 1));
    if ((|int_q[INT_W-1:6]) || (|sh_res[RES_W-1:64]))
      out_d = '1;
    else
      out_d = sh_res[63:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      int_q     <= '0;
      frac_q    <= '0;
      m_q       <= '0;
      k_q       <= '0;
      outdata_q <= '0;
      dv_q      <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      dv_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start && rst_sync_q[1]) begin
            int_q   <= indata[FRAC_BITS+INT_W-1:FRAC_BITS];
            frac_q  <= indata[FRAC_BITS-1:0];
            m_q     <= ONE;
            k_q     <= 4'd1;
            busy_q  <= 1'b1;
            state_q <= S_MUL;
          end
        end
        S_MUL: begin
          // frac_q shifts left so its MSB is always the bit for iteration k.
          if (frac_q[FRAC_BITS-1]) m_q <= m_d;
          frac_q <= frac_q << 1;
          if (k_q == K_LAST) state_q <= S_SHIFT;
          else               k_q     <= k_q + 4'd1;
        end
        S_SHIFT: begin
          outdata_q <= out_d;
          dv_q      <= 1'b1;
          // busy drops together with dv so upstream can re-issue at once.
          busy_q    <= 1'b0;
          state_q   <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign outdata = outdata_q;
  assign dv      = dv_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_exp2_10bit.sv
module tb_exp2_10bit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [20:0] indata;
  logic [63:0] outdata;
  logic        dv;
  logic        busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  exp2_10bit #(.FRAC_BITS(10), .MANT_W(24)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .indata  (indata),
    .outdata (outdata),
    .dv      (dv),
    .busy    (busy)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic real rabs(input real a);
    return (a < 0.0) ? -a : a;
  endfunction

  // Single conversion from idle; waits at most 20 cycles for dv.
  task automatic run_one(input logic [20:0] v, output logic [63:0] res, output int lat);
    indata = v;
    start  = 1'b1;
    tick;
    start  = 1'b0;
    lat    = -1;
    for (int i = 1; i <= 20; i++) begin
      tick;
      if (dv) begin
        lat = i;
        break;
      end
    end
    res = outdata;
    tick;
  endtask

  task automatic test_reset;
    rst_n  = 1'b0;
    start  = 1'b0;
    indata = '0;
    tick; tick;
    checks++;
    if (outdata !== 64'd0) begin errors++; $display("FAIL reset_outdata got %h want 0", outdata); end
    checks++;
    if (dv !== 1'b0) begin errors++; $display("FAIL reset_dv got %b want 0", dv); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    // Release and request immediately: the first edge must not accept.
    rst_n = 1'b1;
    start = 1'b1;
    tick;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_early_accept busy got %b want 0", busy); end
    start = 1'b0;
    tick; tick; tick;
  endtask

  task automatic test_latency;
    int bad;
    indata = 21'd0;
    start  = 1'b1;
    tick;
    start  = 1'b0;
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL lat_busy_after_accept got %b want 1", busy); end
    bad = 0;
    for (int i = 1; i <= 10; i++) begin
      tick;
      if (dv !== 1'b0 || busy !== 1'b1) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL lat_early_dv bad_cycles %0d want 0", bad); end
    tick;
    checks++;
    if (dv !== 1'b1) begin errors++; $display("FAIL lat_dv_at_11 got %b want 1", dv); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL lat_busy_with_dv got %b want 0", busy); end
    checks++;
    if (outdata !== 64'd1) begin errors++; $display("FAIL zero_value got %0d want 1", outdata); end
    tick;
    checks++;
    if (dv !== 1'b0) begin errors++; $display("FAIL dv_width got %b want 0", dv); end
  endtask

  task automatic test_values;
    logic [63:0] res;
    int lat;
    real ex, err;
    run_one(21'd10240, res, lat);
    checks++;
    if (res !== 64'd1024 || lat != 11) begin errors++; $display("FAIL val_10p0 got %0d lat %0d want 1024 lat 11", res, lat); end
    run_one(21'd20992, res, lat);
    checks++;
    if (res < 64'd1482909 || res > 64'd1482911 || lat != 11) begin
      errors++; $display("FAIL val_20p5 got %0d lat %0d want 1482910+-1 lat 11", res, lat);
    end
    run_one(21'd65536, res, lat);
    checks++;
    if (res !== 64'hFFFF_FFFF_FFFF_FFFF) begin errors++; $display("FAIL sat_int64 got %h want all ones", res); end
    run_one(21'h1FFFFF, res, lat);
    checks++;
    if (res !== 64'hFFFF_FFFF_FFFF_FFFF) begin errors++; $display("FAIL sat_max got %h want all ones", res); end
    run_one(21'd64511, res, lat);
    ex  = 2.0 ** (64511.0 / 1024.0);
    err = rabs(real'(res) - ex);
    checks++;
    if (err > ex * (2.0 ** -20)) begin errors++; $display("FAIL val_62p999 got %0d want %e rel 2^-20", res, ex); end
  endtask

  task automatic test_roundtrip;
    logic [63:0] res;
    int lat;
    // log2(548674) = 19.06559 -> Q11.10 19523
    run_one(21'd19523, res, lat);
    checks++;
    if (res < 64'd548290 || res > 64'd549058) begin
      errors++; $display("FAIL roundtrip got %0d want 548674 +-0.07%%", res);
    end
  endtask

  function automatic logic [20:0] gen(input int j);
    if (j % 25 == 24) return 21'(65536 + j);
    return 21'($urandom_range(0, 64511));
  endfunction

  task automatic test_back_to_back;
    logic [20:0] cur, nxt;
    int bad;
    real ex, err;
    cur    = gen(0);
    indata = cur;
    start  = 1'b1;
    for (int j = 0; j < 100; j++) begin
      nxt = gen(j + 1);
      bad = 0;
      tick;                         // accept edge
      if (dv !== 1'b0) bad++;
      for (int t = 1; t <= 10; t++) begin
        indata = 21'($urandom);     // must not disturb the in-flight value
        tick;
        if (dv !== 1'b0) bad++;
      end
      indata = 21'($urandom);
      tick;
      if (dv !== 1'b1 || busy !== 1'b0) bad++;
      checks++;
      if (bad != 0) begin errors++; $display("FAIL b2b_timing idx %0d bad_cycles %0d want 0", j, bad); end
      checks++;
      if (cur[20:10] >= 11'd64) begin
        if (outdata !== 64'hFFFF_FFFF_FFFF_FFFF) begin
          errors++; $display("FAIL b2b_sat idx %0d in %0d got %h want all ones", j, cur, outdata);
        end
      end else begin
        ex  = 2.0 ** (real'(cur) / 1024.0);
        err = rabs(real'(outdata) - ex);
        if (err > ex * (2.0 ** -19) + 1.0) begin
          errors++; $display("FAIL b2b_value idx %0d in %0d got %0d want %e", j, cur, outdata, ex);
        end
      end
      cur    = nxt;
      indata = cur;
      if (j == 99) start = 1'b0;
    end
    tick; tick;
  endtask

  task automatic test_reset_mid;
    logic [63:0] res;
    int lat, bad;
    indata = 21'd10240;
    start  = 1'b1;
    tick;
    start  = 1'b0;
    tick; tick; tick; tick;         // iterations 1..4 done
    rst_n = 1'b0;
    #1;
    checks++;
    if (outdata !== 64'd0 || dv !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL mid_reset_outputs out %h dv %b busy %b want 0 0 0", outdata, dv, busy);
    end
    tick; tick;
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 14; i++) begin
      tick;
      if (dv !== 1'b0 || busy !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL mid_reset_no_dv bad_cycles %0d want 0", bad); end
    run_one(21'd20992, res, lat);
    checks++;
    if (lat != 11 || res < 64'd1482909 || res > 64'd1482911) begin
      errors++; $display("FAIL mid_reset_restart got %0d lat %0d want 1482910 lat 11", res, lat);
    end
  endtask

  initial begin
    test_reset;
    test_latency;
    test_values;
    test_roundtrip;
    test_back_to_back;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
